// File: rtl/prbs_gen_chk_if.sv
// Link BER test bus: TX pattern controls and data, RX data and checker status.
interface prbs_gen_chk_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned ERR_W = 32
);
   logic [1:0]       mode;
   logic             load;
   logic [30:0]      seed;
   logic             tx_en;
   logic [W-1:0]     tx_data;
   logic             tx_valid;
   logic             rx_valid;
   logic [W-1:0]     rx_data;
   logic             err_clr;
   logic             locked;
   logic             err_word;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output mode, load, seed, tx_en, rx_valid, rx_data, err_clr,
      input  tx_data, tx_valid, locked, err_word, err_cnt
   );

   modport slave (
      input  mode, load, seed, tx_en, rx_valid, rx_data, err_clr,
      output tx_data, tx_valid, locked, err_word, err_cnt
   );
endinterface

// File: rtl/prbs_gen_chk.sv
// W-bit-per-clock PRBS7/15/23/31 generator plus self-synchronising checker
// with lock FSM and saturating bit-error counter.
module prbs_gen_chk #(
   parameter int unsigned W        = 32,
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned LOSS_CNT = 4,
   parameter int unsigned ERR_W    = 32
) (
   input logic             clk,
   input logic             rst_n,
   prbs_gen_chk_if.slave   bus
);

   localparam int unsigned XW      = W + 31;
   localparam int unsigned RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
   localparam int unsigned CNT_W   = $clog2(RUN_MAX + 1);
   localparam int unsigned POP_W   = $clog2(W + 1);
   localparam int unsigned SUM_W   = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;
   localparam logic [ERR_W-1:0] ERR_SAT = '1;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_SYNC = 1'b1
   } state_e;

   function automatic int tap_n(input int g);
      case (g)
         0:       return 7;
         1:       return 15;
         2:       return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int tap_t(input int g);
      case (g)
         0:       return 6;
         1:       return 14;
         2:       return 18;
         default: return 28;
      endcase
   endfunction

   logic [1:0]       mode_q;
   logic [30:0]      gen_q,      gen_d;
   logic [W-1:0]     tx_data_q,  tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic [30:0]      hist_q,     hist_d;
   state_e           state_q,    state_d;
   logic [CNT_W-1:0] run_q,      run_d;
   logic             err_word_q, err_word_d;
   logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

   logic [XW-1:0]    gen_x [4];
   logic [W-1:0]     err_x [4];

   // Per polynomial: unrolled W-step generator advance and per-bit rx prediction error.
   for (genvar g = 0; g < 4; g++) begin : g_poly
      localparam int N_G = tap_n(g);
      localparam int T_G = tap_t(g);
      logic [XW-1:0] gb;
      logic [XW-1:0] cb;
      logic [W-1:0]  eb;

      always_comb begin
         gb = XW'(gen_q);
         for (int m = N_G; m < int'(XW); m++) begin
            gb[m] = gb[m-N_G] ^ gb[m-N_G+T_G];
         end
      end

      always_comb begin
         cb = {bus.rx_data, hist_q};
         eb = '0;
         for (int i = 0; i < int'(W); i++) begin
            eb[i] = cb[31+i] ^ cb[31+i-N_G] ^ cb[31+i-N_G+T_G];
         end
      end

      assign gen_x[g] = gb;
      assign err_x[g] = eb;
   end

   logic [XW-1:0]    gen_sel;
   logic [XW-1:0]    rx_cat;
   logic [W-1:0]     err_bits;
   logic [30:0]      seed_mask;
   logic [30:0]      seed_ld;
   logic             mode_chg;
   logic [POP_W-1:0] pop;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] run_inc;

   always_comb begin
      gen_d      = gen_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = bus.tx_en & ~bus.load;
      hist_d     = hist_q;
      state_d    = state_q;
      run_d      = run_q;
      err_cnt_d  = err_cnt_q;

      gen_sel  = gen_x[mode_q];
      err_bits = err_x[mode_q];
      rx_cat   = {bus.rx_data, hist_q};
      mode_chg = (bus.mode != mode_q);
      run_inc  = run_q + CNT_W'(1);
      err_word_d = bus.rx_valid & (|err_bits);

      case (mode_q)
         2'd0:    seed_mask = 31'h0000_007F;
         2'd1:    seed_mask = 31'h0000_7FFF;
         2'd2:    seed_mask = 31'h007F_FFFF;
         default: seed_mask = 31'h7FFF_FFFF;
      endcase
      // An all-zero register would lock the LFSR up; substitute all ones.
      seed_ld = ((bus.seed & seed_mask) == 31'd0) ? '1 : bus.seed;

      pop = '0;
      for (int i = 0; i < int'(W); i++) begin
         pop = pop + POP_W'(err_bits[i]);
      end
      sum = SUM_W'(err_cnt_q) + SUM_W'(pop);

      if (bus.load) begin
         gen_d = seed_ld;
      end else if (bus.tx_en) begin
         gen_d     = gen_sel[XW-1 -: 31];
         tx_data_d = gen_sel[W-1:0];
      end

      if (bus.rx_valid) begin
         hist_d = rx_cat[XW-1 -: 31];
      end

      if (mode_chg) begin
         state_d = ST_HUNT;
         run_d   = '0;
      end else if (bus.rx_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (err_bits != '0) begin
                  run_d = '0;
               end else if (run_inc == CNT_W'(LOCK_CNT)) begin
                  state_d = ST_SYNC;
                  run_d   = '0;
               end else begin
                  run_d = run_inc;
               end
            end
            default: begin
               if (err_bits == '0) begin
                  run_d = '0;
               end else if (run_inc == CNT_W'(LOSS_CNT)) begin
                  state_d = ST_HUNT;
                  run_d   = '0;
               end else begin
                  run_d = run_inc;
               end
            end
         endcase
      end

      if (bus.err_clr) begin
         err_cnt_d = '0;
      end else if (bus.rx_valid && (state_q == ST_SYNC)) begin
         err_cnt_d = (sum > SUM_W'(ERR_SAT)) ? ERR_SAT : ERR_W'(sum);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= 2'd0;
         gen_q      <= '1;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         hist_q     <= '0;
         state_q    <= ST_HUNT;
         run_q      <= '0;
         err_word_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         mode_q     <= bus.mode;
         gen_q      <= gen_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         hist_q     <= hist_d;
         state_q    <= state_d;
         run_q      <= run_d;
         err_word_q <= err_word_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.locked   = (state_q == ST_SYNC);
   assign bus.err_word = err_word_q;
   assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: two instances (W=32/ERR_W=32 and W=8/ERR_W=4) checked
// against a bit-serial queue model of the PRBS sequence and the lock rules.
module tb_prbs_gen_chk;
   localparam int LOCK = 8;
   localparam int LOSS = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prbs_gen_chk_if #(.W(32), .ERR_W(32)) if_a ();
   prbs_gen_chk_if #(.W(8),  .ERR_W(4))  if_b ();

   prbs_gen_chk #(.W(32), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(32)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   prbs_gen_chk #(.W(8), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   int checks = 0;
   int failures = 0;

   int               cur_d;
   int               cur_w;
   longint unsigned  cur_max;
   logic [1:0]       cur_mode;

   // Reference model: sequence bits as queues, lock state as plain counters.
   int               md;
   bit               gq[$];
   bit               rq[$];
   bit               m_sync;
   int               m_run;
   longint unsigned  m_cnt;
   logic [63:0]      exp_tx;
   bit               exp_txv;
   bit               exp_errw;

   function automatic int pn(input int m);
      case (m) 0: return 7; 1: return 15; 2: return 23; default: return 31; endcase
   endfunction
   function automatic int pt(input int m);
      case (m) 0: return 6; 1: return 14; 2: return 18; default: return 28; endcase
   endfunction

   function automatic logic [63:0] o_tx();
      if (cur_d == 0) return 64'(if_a.tx_data);
      return 64'(if_b.tx_data);
   endfunction
   function automatic logic [63:0] o_txv();
      if (cur_d == 0) return 64'(if_a.tx_valid);
      return 64'(if_b.tx_valid);
   endfunction
   function automatic logic [63:0] o_lock();
      if (cur_d == 0) return 64'(if_a.locked);
      return 64'(if_b.locked);
   endfunction
   function automatic logic [63:0] o_errw();
      if (cur_d == 0) return 64'(if_a.err_word);
      return 64'(if_b.err_word);
   endfunction
   function automatic logic [63:0] o_cnt();
      if (cur_d == 0) return 64'(if_a.err_cnt);
      return 64'(if_b.err_cnt);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      if_a.mode = 2'd0; if_a.load = 1'b0; if_a.seed = '0; if_a.tx_en = 1'b0;
      if_a.rx_valid = 1'b0; if_a.rx_data = '0; if_a.err_clr = 1'b0;
      if_b.mode = 2'd0; if_b.load = 1'b0; if_b.seed = '0; if_b.tx_en = 1'b0;
      if_b.rx_valid = 1'b0; if_b.rx_data = '0; if_b.err_clr = 1'b0;
   endtask

   task automatic drive(input bit ld, input logic [30:0] sd, input bit te, input bit rv,
                        input logic [63:0] rd, input bit clr);
      if (cur_d == 0) begin
         if_a.mode = cur_mode; if_a.load = ld; if_a.seed = sd; if_a.tx_en = te;
         if_a.rx_valid = rv; if_a.rx_data = rd[31:0]; if_a.err_clr = clr;
      end else begin
         if_b.mode = cur_mode; if_b.load = ld; if_b.seed = sd; if_b.tx_en = te;
         if_b.rx_valid = rv; if_b.rx_data = rd[7:0]; if_b.err_clr = clr;
      end
   endtask

   task automatic m_reset();
      md = 0;
      gq.delete();
      for (int i = 0; i < 7; i++) gq.push_back(1'b1);
      rq.delete();
      for (int i = 0; i < 31; i++) rq.push_back(1'b0);
      m_sync = 1'b0; m_run = 0; m_cnt = 0;
      exp_tx = '0; exp_txv = 1'b0; exp_errw = 1'b0;
   endtask

   task automatic m_load(input logic [30:0] sd);
      int n;
      logic [30:0] mask;
      n = pn(md);
      mask = 31'((64'd1 << n) - 64'd1);
      if ((sd & mask) == 31'd0) sd = '1;
      gq.delete();
      for (int i = 0; i < n; i++) gq.push_back(sd[i]);
   endtask

   // s_(m+N) = s_m ^ s_(m+T); gq holds the next N bits, oldest first.
   task automatic m_gen(output logic [63:0] w);
      int t;
      t = pt(md);
      w = '0;
      for (int i = 0; i < cur_w; i++) begin
         w[i] = gq[0];
         gq.push_back(gq[0] ^ gq[t]);
         void'(gq.pop_front());
      end
   endtask

   task automatic m_chk(input logic [63:0] rd, output int e);
      int n, t;
      bit pred;
      n = pn(md); t = pt(md); e = 0;
      for (int i = 0; i < cur_w; i++) begin
         pred = rq[31-n] ^ rq[31-n+t];
         if (rd[i] != pred) e++;
         rq.push_back(rd[i]);
         void'(rq.pop_front());
      end
   endtask

   // One clock: optional load, optional word sent and looped back (with injected flips).
   task automatic step(input bit ld, input logic [30:0] sd, input bit te,
                       input logic [63:0] inj, input bit clr, input string tag);
      logic [63:0] w, rd, wm;
      bit mchg, rv, was_sync;
      int e;
      w = '0;
      wm = (cur_w == 64) ? '1 : ((64'd1 << cur_w) - 64'd1);
      mchg = (int'(cur_mode) != md);
      rv = te && !ld;
      if (ld) begin
         m_load(sd); exp_txv = 1'b0;
      end else if (te) begin
         m_gen(w); exp_tx = w; exp_txv = 1'b1;
      end else begin
         exp_txv = 1'b0;
      end
      rd = (w ^ inj) & wm;
      drive(ld, sd, te, rv, rd, clr);
      e = 0;
      if (rv) m_chk(rd, e);
      exp_errw = rv && (e > 0);
      was_sync = m_sync;
      if (clr) m_cnt = 0;
      else if (rv && was_sync) m_cnt = (m_cnt + longint'(e) > cur_max) ? cur_max : m_cnt + longint'(e);
      if (mchg) begin
         m_sync = 1'b0; m_run = 0;
      end else if (rv) begin
         if (!m_sync) begin
            if (e == 0) begin
               m_run++;
               if (m_run == LOCK) begin m_sync = 1'b1; m_run = 0; end
            end else m_run = 0;
         end else begin
            if (e > 0) begin
               m_run++;
               if (m_run == LOSS) begin m_sync = 1'b0; m_run = 0; end
            end else m_run = 0;
         end
      end
      md = int'(cur_mode);
      @(posedge clk);
      #1;
      chk($sformatf("%s.tx_data", tag),  o_tx(),   exp_tx);
      chk($sformatf("%s.tx_valid", tag), o_txv(),  64'(exp_txv));
      chk($sformatf("%s.locked", tag),   o_lock(), 64'(m_sync));
      chk($sformatf("%s.err_word", tag), o_errw(), 64'(exp_errw));
      chk($sformatf("%s.err_cnt", tag),  o_cnt(),  64'(m_cnt));
   endtask

   task automatic chk_zero(input string tag);
      chk($sformatf("%s.tx_data", tag),  o_tx(),   64'd0);
      chk($sformatf("%s.tx_valid", tag), o_txv(),  64'd0);
      chk($sformatf("%s.locked", tag),   o_lock(), 64'd0);
      chk($sformatf("%s.err_word", tag), o_errw(), 64'd0);
      chk($sformatf("%s.err_cnt", tag),  o_cnt(),  64'd0);
   endtask

   function automatic logic [30:0] rnd_seed();
      if ($urandom_range(0, 3) == 0) return 31'd0;
      return 31'($urandom);
   endfunction

   initial begin
      longint unsigned pre;
      int r, te, clr;
      logic [63:0] inj;

      rst_n = 1'b0;
      idle_all();
      cur_d = 0; cur_w = 32; cur_max = 64'hFFFF_FFFF; cur_mode = 2'd0;
      m_reset();
      #12;
      chk_zero("reset_a");
      @(negedge clk) rst_n = 1'b1;

      // Loopback per polynomial: lock after history fill, no counted errors.
      for (int m = 0; m < 4; m++) begin
         cur_mode = 2'(m);
         step(1'b0, '0, 1'b0, '0, 1'b0, "mode_set");
         step(1'b1, rnd_seed(), 1'b0, '0, 1'b0, "load");
         for (int k = 0; k < 40; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "loopback");
         chk("loopback_locked", o_lock(), 64'd1);
         chk("loopback_cnt0", o_cnt(), 64'd0);
      end

      // Mode change while locked drops lock on the next clock.
      cur_mode = 2'd0;
      step(1'b0, '0, 1'b0, '0, 1'b0, "mode_chg");
      chk("mode_chg_unlock", o_lock(), 64'd0);
      step(1'b1, 31'd0, 1'b0, '0, 1'b0, "zero_seed");
      for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "zs_loop");

      // Single line flip: three counted errors, one err_word pulse, lock kept.
      pre = m_cnt;
      step(1'b0, '0, 1'b1, 64'h20, 1'b0, "flip5");
      chk("flip5_errword", o_errw(), 64'd1);
      step(1'b0, '0, 1'b1, '0, 1'b0, "flip5_after");
      chk("flip5_plus3", o_cnt(), 64'(pre + 3));
      chk("flip5_errword_clear", o_errw(), 64'd0);
      chk("flip5_locked", o_lock(), 64'd1);

      // Four inverted words lose lock; counter frozen afterwards.
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 64'hFFFF_FFFF, 1'b0, "invert");
      chk("invert_unlock", o_lock(), 64'd0);
      pre = m_cnt;
      for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "post_invert");
      chk("cnt_frozen", o_cnt(), 64'(pre));

      // Relock, then clear concurrent with an error.
      for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "relock");
      step(1'b0, '0, 1'b1, 64'h20, 1'b1, "clr_with_err");
      chk("clr_wins", o_cnt(), 64'd0);

      // Randomised traffic: idles, flips, bursts, clears, mode changes, loads.
      for (int k = 0; k < 1500; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            cur_mode = 2'($urandom);
            step(1'b0, '0, 1'b0, '0, 1'b0, "rnd_mode");
            step(1'b1, rnd_seed(), 1'($urandom), '0, 1'b0, "rnd_load");
         end else begin
            te = (r >= 12) ? 1 : 0;
            clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            inj = '0;
            if ($urandom_range(0, 19) == 0) inj[$urandom_range(0, 31)] = 1'b1;
            else if ($urandom_range(0, 59) == 0) inj = 64'h0000_0000_FFFF_FFFF;
            step(1'b0, '0, 1'(te), inj, 1'(clr), "rnd");
         end
      end

      // Asynchronous reset mid-run.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk_zero("async_rst_a");
      idle_all();
      cur_mode = 2'd0;
      m_reset();
      @(negedge clk) rst_n = 1'b1;
      step(1'b1, 31'h1234_5678, 1'b0, '0, 1'b0, "post_rst_load");
      for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "post_rst");

      // Narrow instance: known PRBS7 words and counter saturation.
      cur_d = 1; cur_w = 8; cur_max = 64'd15; cur_mode = 2'd0;
      rst_n = 1'b0;
      idle_all();
      m_reset();
      #12;
      chk_zero("reset_b");
      @(negedge clk) rst_n = 1'b1;
      step(1'b1, 31'h7F, 1'b0, '0, 1'b0, "b_load7f");
      step(1'b0, '0, 1'b1, '0, 1'b0, "b_w0");
      chk("b_word0_7f", o_tx(), 64'h7F);
      step(1'b0, '0, 1'b1, '0, 1'b0, "b_w1");
      chk("b_word1_95", o_tx(), 64'h95);
      for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "b_loop");
      chk("b_locked", o_lock(), 64'd1);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, '0, 1'b1, 64'h20, 1'b0, "b_flip");
         step(1'b0, '0, 1'b1, '0, 1'b0, "b_gap");
         step(1'b0, '0, 1'b1, '0, 1'b0, "b_gap");
      end
      chk("b_saturated", o_cnt(), 64'd15);
      chk("b_sat_locked", o_lock(), 64'd1);
      step(1'b0, '0, 1'b1, 64'h20, 1'b1, "b_clr_with_err");
      chk("b_clr_wins", o_cnt(), 64'd0);
      for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, '0, 1'b0, "b_tail");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
